speed_arbiter: RTL and testbench

SPEED_ARBITER -- requirements
Module: speed_arbiter

---
 rtl/speed_arbiter.sv | 148 ++++++++++++++
 tb/tb_speed_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_arbiter.sv
// Speed step arbiter: merges manual inc/dec pulses and a prescaled auto-ramp tick into single
// ENABLE/UP_DOWN strobes for an up/down counter; 2-cycle request-to-strobe latency, GAP-cycle cooldown.
module speed_arbiter #(
  parameter int MAX_SPEED = 9,
  parameter int MIN_SPEED = 0,
  parameter int RAMP_DIV  = 25_000_000,
  parameter int GAP       = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       INC_REQ,
  input  logic       DEC_REQ,
  input  logic       AUTO_EN,
  input  logic       AUTO_UP,
  output logic       ENABLE,
  output logic       UP_DOWN,
  output logic [3:0] SPEED,
  output logic       AT_MAX,
  output logic       AT_MIN,
  output logic       BUSY
);

  localparam logic [3:0]  SPD_MAX  = 4'(MAX_SPEED);
  localparam logic [3:0]  SPD_MIN  = 4'(MIN_SPEED);
  localparam logic [25:0] DIV_LAST = 26'(RAMP_DIV - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEP     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t      state, state_n;
  logic        enable_n, up_down_n, busy_n;
  logic [3:0]  speed_n;
  logic [3:0]  gap_cnt, gap_n;
  logic        inc_p, dec_p, auto_p;
  logic        inc_n, dec_n, auto_n;
  logic        inc_keep, dec_keep, drop_auto;
  logic        pick, go_up;
  logic [25:0] presc, presc_n;

  assign AT_MAX = (SPEED == SPD_MAX);
  assign AT_MIN = (SPEED == SPD_MIN);

  always_comb begin
    state_n   = state;
    enable_n  = 1'b0;
    up_down_n = 1'b0;
    speed_n   = SPEED;
    gap_n     = gap_cnt;
    inc_keep  = inc_p;
    dec_keep  = dec_p;
    drop_auto = 1'b0;
    pick      = 1'b0;
    go_up     = 1'b0;
    inc_n     = 1'b0;
    dec_n     = 1'b0;
    auto_n    = auto_p;
    presc_n   = presc;

    case (state)
      IDLE: begin
        // Manual requests win; the auto tick is dropped whenever anything is picked.
        if (inc_p) begin
          pick     = 1'b1;
          go_up    = 1'b1;
          inc_keep = 1'b0;
        end else if (dec_p) begin
          pick     = 1'b1;
          go_up    = 1'b0;
          dec_keep = 1'b0;
        end else if (auto_p) begin
          pick  = 1'b1;
          go_up = AUTO_UP;
        end
        drop_auto = pick;
        if (pick && !(go_up ? AT_MAX : AT_MIN)) begin
          state_n   = STEP;
          enable_n  = 1'b1;
          up_down_n = ~go_up;
          speed_n   = go_up ? (SPEED + 4'd1) : (SPEED - 4'd1);
        end
      end
      STEP: begin
        state_n = COOLDOWN;
        gap_n   = GAP_LAST;
      end
      COOLDOWN: begin
        if (gap_cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);

    // Opposing manual requests annihilate, whether simultaneous or one pending.
    inc_n = inc_keep | INC_REQ;
    dec_n = dec_keep | DEC_REQ;
    if (inc_n && dec_n) begin
      inc_n = 1'b0;
      dec_n = 1'b0;
    end

    if (!AUTO_EN) begin
      presc_n = 26'd0;
      auto_n  = 1'b0;
    end else if (presc == DIV_LAST) begin
      presc_n = 26'd0;
      auto_n  = 1'b1;
    end else begin
      presc_n = presc + 26'd1;
      auto_n  = auto_p & ~drop_auto;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      ENABLE  <= 1'b0;
      UP_DOWN <= 1'b0;
      SPEED   <= SPD_MIN;
      BUSY    <= 1'b0;
      gap_cnt <= 4'd0;
      inc_p   <= 1'b0;
      dec_p   <= 1'b0;
      auto_p  <= 1'b0;
      presc   <= 26'd0;
    end else begin
      state   <= state_n;
      ENABLE  <= enable_n;
      UP_DOWN <= up_down_n;
      SPEED   <= speed_n;
      BUSY    <= busy_n;
      gap_cnt <= gap_n;
      inc_p   <= inc_n;
      dec_p   <= dec_n;
      auto_p  <= auto_n;
      presc   <= presc_n;
    end
  end

endmodule

// File: tb/tb_speed_arbiter.sv
// Bench for speed_arbiter: directed scenarios plus random traffic against a timestamp-based model.
module tb_speed_arbiter;

  localparam int MAXS = 3;
  localparam int MINS = 0;
  localparam int DIV  = 8;
  localparam int GAPC = 2;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       INC_REQ = 1'b0;
  logic       DEC_REQ = 1'b0;
  logic       AUTO_EN = 1'b0;
  logic       AUTO_UP = 1'b0;
  logic       ENABLE, UP_DOWN, AT_MAX, AT_MIN, BUSY;
  logic [3:0] SPEED;

  int checks = 0;
  int errors = 0;

  // Model: cycle index plus timestamps of the next strobe and of the return to idle.
  int cyc = 0;
  int m_speed = MINS;
  int m_idle_from = 0;
  int m_step_cycle = -1;
  int m_ticks = 0;
  bit m_inc, m_dec, m_auto, m_dir;

  int en_count = 0;
  int dn_count = 0;
  int last_en_cyc = -1;

  speed_arbiter #(
    .MAX_SPEED(MAXS),
    .MIN_SPEED(MINS),
    .RAMP_DIV (DIV),
    .GAP      (GAPC)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .INC_REQ(INC_REQ),
    .DEC_REQ(DEC_REQ),
    .AUTO_EN(AUTO_EN),
    .AUTO_UP(AUTO_UP),
    .ENABLE (ENABLE),
    .UP_DOWN(UP_DOWN),
    .SPEED  (SPEED),
    .AT_MAX (AT_MAX),
    .AT_MIN (AT_MIN),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_speed      = MINS;
    m_idle_from  = 0;
    m_step_cycle = -1;
    m_ticks      = 0;
    m_inc        = 1'b0;
    m_dec        = 1'b0;
    m_auto       = 1'b0;
    m_dir        = 1'b0;
  endtask

  task automatic compare_outputs();
    bit exp_en;
    bit exp_busy;
    exp_en   = (cyc == m_step_cycle);
    exp_busy = (cyc >= m_step_cycle) && (cyc < m_idle_from);
    check("ENABLE",  32'(ENABLE),  32'(exp_en));
    check("UP_DOWN", 32'(UP_DOWN), 32'(exp_en & m_dir));
    check("SPEED",   32'(SPEED),   32'(m_speed));
    check("AT_MAX",  32'(AT_MAX),  32'(m_speed == MAXS));
    check("AT_MIN",  32'(AT_MIN),  32'(m_speed == MINS));
    check("BUSY",    32'(BUSY),    32'(exp_busy));
  endtask

  // Effect of one rising edge, using the inputs presented during the current cycle.
  task automatic model_edge();
    bit take, up, cons_inc, cons_dec, ni, nd;
    take = 1'b0; up = 1'b0; cons_inc = 1'b0; cons_dec = 1'b0;
    if (cyc >= m_idle_from) begin
      if (m_inc) begin
        take = 1'b1; up = 1'b1; cons_inc = 1'b1;
      end else if (m_dec) begin
        take = 1'b1; up = 1'b0; cons_dec = 1'b1;
      end else if (m_auto) begin
        take = 1'b1; up = AUTO_UP;
      end
      if (take && (up ? (m_speed < MAXS) : (m_speed > MINS))) begin
        m_speed      = up ? m_speed + 1 : m_speed - 1;
        m_dir        = !up;
        m_step_cycle = cyc + 1;
        m_idle_from  = cyc + 2 + GAPC;
      end
    end
    ni = (m_inc && !cons_inc) || INC_REQ;
    nd = (m_dec && !cons_dec) || DEC_REQ;
    if (ni && nd) begin
      ni = 1'b0; nd = 1'b0;
    end
    m_inc = ni;
    m_dec = nd;
    if (!AUTO_EN) begin
      m_ticks = 0;
      m_auto  = 1'b0;
    end else begin
      m_ticks++;
      if (m_ticks == DIV) begin
        m_ticks = 0;
        m_auto  = 1'b1;
      end else if (take) begin
        m_auto = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit inc, input bit dec, input bit aen, input bit aup);
    INC_REQ = inc;
    DEC_REQ = dec;
    AUTO_EN = aen;
    AUTO_UP = aup;
    @(negedge CLK);
    compare_outputs();
    if (ENABLE === 1'b1) begin
      en_count++;
      last_en_cyc = cyc;
      if (UP_DOWN === 1'b1) dn_count++;
    end
    @(posedge CLK);
    if (RSTn) model_edge();
    else cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    RSTn = 1'b0;
    model_reset();
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    RSTn = 1'b1;
  endtask

  initial begin
    int e0, d0, req_cyc;
    bit aen, aup;
    model_reset();
    #1;

    // Reset state and single increment latency
    do_reset(3);
    check("rst_speed", 32'(SPEED), 32'(MINS));
    check("rst_at_min", 32'(AT_MIN), 32'd1);
    idle(7);
    e0 = en_count;
    req_cyc = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("inc_latency", 32'(last_en_cyc - req_cyc), 32'd2);
    check("inc_pulses", 32'(en_count - e0), 32'd1);
    check("inc_speed", 32'(SPEED), 32'd1);

    // Four increments saturate at MAX; the fourth is silent
    do_reset(2);
    e0 = en_count;
    repeat (4) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);
    end
    check("sat_pulses", 32'(en_count - e0), 32'd3);
    check("sat_speed", 32'(SPEED), 32'(MAXS));
    check("sat_at_max", 32'(AT_MAX), 32'd1);

    // Auto ramp down to MIN then stop
    e0 = en_count;
    d0 = dn_count;
    repeat (40) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("ramp_pulses", 32'(en_count - e0), 32'd3);
    check("ramp_dn", 32'(dn_count - d0), 32'd3);
    check("ramp_speed", 32'(SPEED), 32'(MINS));
    check("ramp_at_min", 32'(AT_MIN), 32'd1);

    // Simultaneous inc/dec cancel
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    e0 = en_count;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(8);
    check("cancel_pulses", 32'(en_count - e0), 32'd0);
    check("cancel_speed", 32'(SPEED), 32'd1);

    // Auto-up tick coinciding with a manual decrement: decrement wins, tick dropped
    e0 = en_count;
    d0 = dn_count;
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(6);
    check("prio_pulses", 32'(en_count - e0), 32'd1);
    check("prio_dn", 32'(dn_count - d0), 32'd1);
    check("prio_speed", 32'(SPEED), 32'(MINS));

    // Reset during cooldown with an increment pending
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    e0 = en_count;
    idle(20);
    check("abort_pulses", 32'(en_count - e0), 32'd0);
    check("abort_speed", 32'(SPEED), 32'(MINS));
    req_cyc = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("abort_relatency", 32'(last_en_cyc - req_cyc), 32'd2);

    // Random traffic against the model
    aen = 1'b0;
    aup = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) aen = ~aen;
      if ($urandom_range(0, 39) == 0) aup = ~aup;
      if (i == 300) do_reset(2);
      step($urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0, aen, aup);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
